fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised hazard/forwarding block for the 5-stage pipeline and its multi-cycle extensions. It adds a per-register scoreboard with latency countdown, so multi-cycle producers (loads, MUL/DIV) stall dependent instructions in ID. It also generalises operand forwarding to NSRC source operands and NSTAGES forwardable pipeline stages, with youngest-stage priority. It sits between the ID/EX control logic and the EX operand muxes, and drives the pipeline stall.

## Interface
- NREGS, 32, architectural register count; register 0 is hard-wired zero.
- RW, $clog2(NREGS), register-index width.
- NSRC, 2, source operands per instruction.
- NSTAGES, 2, forwardable stages after EX; index 0 = EX/MEM (youngest), index NSTAGES-1 = oldest.
- MAXLAT, 4, maximum producer latency in cycles.
- LW, $clog2(MAXLAT+1), countdown width.
- SW, $clog2(NSTAGES+1), forward-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, **synchronous, active-low**.
- id_src_valid  in  NSRC  source i in ID actually reads a register.
- id_src_rd  in  NSRC*RW  ID source register indices, packed, source i at [i*RW +: RW].
- iss_valid  in  1  instruction in ID requests issue to EX.
- iss_regwrite  in  1  issuing instruction writes a register.
- iss_rd  in  RW  issuing destination register.
- iss_lat  in  LW  cycles until the result appears on stage bus 0; values above MAXLAT are clamped to MAXLAT.
- wb_valid  in  1  a register write-back occurs this cycle.
- wb_rd  in  RW  write-back destination.
- ex_src_rd  in  NSRC*RW  EX-stage source indices, packed.
- stg_regwrite  in  NSTAGES  stage k carries a register write.
- stg_rd  in  NSTAGES*RW  stage k destination, packed.
- stall  out  1  hold IF/ID and insert a bubble into EX.
- fwd_sel  out  NSRC*SW  per source: 0 = register file, k+1 = forward from stage k.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- State per register r ≥ 1: busy[r] and cnt[r][LW-1:0]. Register 0 is never busy.
- Stall (combinational): asserted if any source i has id_src_valid[i], id_src_rd ≠ 0, busy[id_src_rd] = 1 and cnt[id_src_rd] ≠ 0.
- Issue fires when iss_valid, iss_regwrite, iss_rd ≠ 0 and !stall. On fire: busy[iss_rd] ← 1, cnt[iss_rd] ← min(iss_lat, MAXLAT).
- Countdown: every busy entry with cnt ≠ 0 decrements by 1 each cycle, except an entry being reloaded by issue. cnt never wraps below 0.
- Retire: wb_valid with wb_rd ≠ 0 clears busy[wb_rd].
  - Retire of a non-busy register has no effect.
  - Issue and retire to the same register in the same cycle: issue wins (busy = 1, cnt reloaded).
- Forwarding (combinational): for each source i with ex_src_rd ≠ 0, fwd_sel = k+1 for the lowest k with stg_regwrite[k] and stg_rd[k] = ex_src_rd. Otherwise fwd_sel = 0. A younger stage always overrides an older one.
- stall_cnt increments on every cycle stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (rst_n = 0 at the clock edge):
  - all busy = 0, all cnt = 0, stall_cnt = 0;
  - stall and fwd_sel then evaluate to 0 for any inputs.
- Reset mid-operation discards all pending entries. The first cycle after reset never stalls.
- stall depends only on registered state and current ID inputs. There is no added cycle of latency.
- For a producer issued at edge t0 with latency L ≥ 1, a dependent instruction in ID stalls during cycles t0+1 … t0+L and issues in cycle t0+L+1.
- L = 0 (single-cycle ALU op) never causes a stall; the dependency is resolved purely by fwd_sel.
- The scoreboard write at the issue edge is visible to the stall logic in the next cycle.

## Structure
- Shared package fwd_pkg holds:
  - the fwd_sel encoding constants (FWD_RF = 0, FWD_STG0 = 1, …);
  - the default NREGS, MAXLAT and NSTAGES.
- Sub-module fwd_sel_prio: one instance per source, generated NSRC times. It is a combinational priority matcher of one source index against NSTAGES stage destinations.
- The scoreboard array and stall counter are inline in fwd_scoreboard.

## Test plan
- Reset:
  - stimulus: assert rst_n = 0 with busy entries pending; release.
  - required: stall = 0, stall_cnt = 0; a source reading a previously busy register does not stall.
- Load-use:
  - stimulus: issue rd = 5 with lat = 2; next cycle ID source 0 reads r5.
  - required: stall high for exactly 2 cycles, then low; stall_cnt = 2.
- Forward priority:
  - stimulus: stg_rd = {5, 5} with both stg_regwrite set and ex_src_rd[0] = 5.
  - required: fwd_sel[0] = 1. Clear stg_regwrite[0] and fwd_sel[0] must become 2.
- Register zero:
  - stimulus: issue rd = 0 with lat = 4, and a stage writing r0.
  - required: no stall; fwd_sel = 0.
- Simultaneous issue and retire on r7:
  - stimulus: same-cycle wb_rd = 7 and issue rd = 7 with lat = 3.
  - required: busy[r7] stays set; a reader of r7 stalls for 3 cycles.
- Clamp and saturation:
  - stimulus: iss_lat = MAXLAT+3; separately, force more than 65535 stall cycles.
  - required: stall lasts exactly MAXLAT cycles; stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants for the hazard/forwarding block: default sizing and the
// forward-select encoding (0 = register file, k+1 = stage k).
package fwd_pkg;

  localparam int NREGS_DEF   = 32;
  localparam int MAXLAT_DEF  = 4;
  localparam int NSTAGES_DEF = 2;

  localparam int FWD_RF   = 0;
  localparam int FWD_STG0 = 1;
  localparam int FWD_STG1 = 2;

  function automatic int fwd_stage_code(input int k);
    return FWD_STG0 + k;
  endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Combinational priority matcher of one EX source index against the stage
// destinations; the youngest matching stage (lowest index) wins.
module fwd_sel_prio
  import fwd_pkg::*;
#(
  parameter int RW      = 5,
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int SW      = $clog2(NSTAGES + 1)
) (
  input  logic [RW-1:0]         src_rd,
  input  logic [NSTAGES-1:0]    stg_regwrite,
  input  logic [NSTAGES*RW-1:0] stg_rd,
  output logic [SW-1:0]         sel
);

  always_comb begin
    sel = SW'(FWD_RF);
    if (src_rd != '0) begin
      // Walk oldest to youngest so a younger match overwrites an older one.
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (stg_regwrite[k] && (stg_rd[k*RW +: RW] == src_rd)) begin
          sel = SW'(fwd_stage_code(k));
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Per-register latency scoreboard that stalls ID on multi-cycle producers,
// plus per-source operand forwarding select and a saturating stall counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int RW      = $clog2(NREGS),
  parameter int NSRC    = 2,
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int MAXLAT  = MAXLAT_DEF,
  parameter int LW      = $clog2(MAXLAT + 1),
  parameter int SW      = $clog2(NSTAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       id_src_valid,
  input  logic [NSRC*RW-1:0]    id_src_rd,
  input  logic                  iss_valid,
  input  logic                  iss_regwrite,
  input  logic [RW-1:0]         iss_rd,
  input  logic [LW-1:0]         iss_lat,
  input  logic                  wb_valid,
  input  logic [RW-1:0]         wb_rd,
  input  logic [NSRC*RW-1:0]    ex_src_rd,
  input  logic [NSTAGES-1:0]    stg_regwrite,
  input  logic [NSTAGES*RW-1:0] stg_rd,
  output logic                  stall,
  output logic [NSRC*SW-1:0]    fwd_sel,
  output logic [15:0]           stall_cnt
);

  localparam logic [LW-1:0] MAXLAT_W = LW'(MAXLAT);

  logic [NREGS-1:0] busy;
  logic [LW-1:0]    cnt [NREGS];
  logic             stall_raw;
  logic             fire;
  logic [LW-1:0]    lat_clamped;
  logic [NSRC*SW-1:0] sel_raw;

  always_comb begin
    stall_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_valid[i] && (id_src_rd[i*RW +: RW] != '0) &&
          busy[id_src_rd[i*RW +: RW]] && (cnt[id_src_rd[i*RW +: RW]] != '0)) begin
        stall_raw = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held.
  assign stall       = rst_n & stall_raw;
  assign fwd_sel     = rst_n ? sel_raw : '0;
  assign fire        = iss_valid && iss_regwrite && (iss_rd != '0) && !stall;
  assign lat_clamped = (iss_lat > MAXLAT_W) ? MAXLAT_W : iss_lat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= '0;
      stall_cnt <= 16'd0;
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (fire && (iss_rd == RW'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= lat_clamped;
        end else begin
          if (wb_valid && (wb_rd == RW'(r))) begin
            busy[r] <= 1'b0;
          end
          if (busy[r] && (cnt[r] != '0)) begin
            cnt[r] <= cnt[r] - LW'(1);
          end
        end
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_sel_prio #(
      .RW      (RW),
      .NSTAGES (NSTAGES),
      .SW      (SW)
    ) u_prio (
      .src_rd       (ex_src_rd[i*RW +: RW]),
      .stg_regwrite (stg_regwrite),
      .stg_rd       (stg_rd),
      .sel          (sel_raw[i*SW +: SW])
    );
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus randomized traffic checked
// against a ready-time reference model.
module tb_fwd_scoreboard;

  localparam int NREGS   = 32;
  localparam int RW      = 5;
  localparam int NSRC    = 2;
  localparam int NSTAGES = 2;
  localparam int MAXLAT  = 4;
  localparam int LW      = 3;
  localparam int SW      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NSRC-1:0]       id_src_valid;
  logic [NSRC*RW-1:0]    id_src_rd;
  logic                  iss_valid;
  logic                  iss_regwrite;
  logic [RW-1:0]         iss_rd;
  logic [LW-1:0]         iss_lat;
  logic                  wb_valid;
  logic [RW-1:0]         wb_rd;
  logic [NSRC*RW-1:0]    ex_src_rd;
  logic [NSTAGES-1:0]    stg_regwrite;
  logic [NSTAGES*RW-1:0] stg_rd;
  logic                  stall;
  logic [NSRC*SW-1:0]    fwd_sel;
  logic [15:0]           stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: a pending register is unavailable until cycle index ready[r].
  bit     pend  [NREGS];
  longint ready [NREGS];
  longint cyc   = 0;
  int     mcnt  = 0;

  fwd_scoreboard #(
    .NREGS(NREGS), .RW(RW), .NSRC(NSRC), .NSTAGES(NSTAGES),
    .MAXLAT(MAXLAT), .LW(LW), .SW(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src_valid(id_src_valid), .id_src_rd(id_src_rd),
    .iss_valid(iss_valid), .iss_regwrite(iss_regwrite),
    .iss_rd(iss_rd), .iss_lat(iss_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_src_rd(ex_src_rd), .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_stall();
    if (!rst_n) return 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      logic [RW-1:0] r;
      r = id_src_rd[i*RW +: RW];
      if (id_src_valid[i] && r != 0 && pend[r] && cyc < ready[r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [SW-1:0] model_fwd(input int i);
    logic [RW-1:0] s;
    s = ex_src_rd[i*RW +: RW];
    if (!rst_n || s == 0) return '0;
    for (int k = 0; k < NSTAGES; k++)
      if (stg_regwrite[k] && stg_rd[k*RW +: RW] == s) return SW'(k + 1);
    return '0;
  endfunction

  task automatic tick();
    bit st;
    bit fire;
    int l;
    st   = model_stall();
    fire = rst_n && iss_valid && iss_regwrite && iss_rd != 0 && !st;
    l    = (int'(iss_lat) > MAXLAT) ? MAXLAT : int'(iss_lat);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) pend[r] = 1'b0;
      mcnt = 0;
    end else begin
      if (wb_valid && wb_rd != 0) pend[wb_rd] = 1'b0;
      if (fire) begin
        pend[iss_rd]  = 1'b1;
        ready[iss_rd] = cyc + l;
      end
      if (st && mcnt < 65535) mcnt++;
    end
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    id_src_valid = '0; id_src_rd = '0;
    iss_valid = 1'b0; iss_regwrite = 1'b0; iss_rd = '0; iss_lat = '0;
    wb_valid = 1'b0; wb_rd = '0;
    ex_src_rd = '0; stg_regwrite = '0; stg_rd = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
    iss_valid = 1'b1; iss_regwrite = 1'b1; iss_rd = rd; iss_lat = lat;
  endtask

  task automatic test_reset();
    do_reset();
    issue(5'd4, 3'd4);
    tick();
    issue(5'd6, 3'd3);
    tick();
    idle();
    rst_n = 1'b0;
    id_src_valid = 2'b01; id_src_rd = {5'd0, 5'd4};
    stg_regwrite = 2'b11; stg_rd = {5'd4, 5'd4}; ex_src_rd = {5'd4, 5'd4};
    settle();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall_in_reset got=%b want=0", stall);
    end
    checks++;
    if (fwd_sel !== 4'd0) begin
      failures++; $display("FAIL reset_fwd_in_reset got=%0h want=0", fwd_sel);
    end
    tick();
    rst_n = 1'b1;
    settle();
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL reset_no_stall_after got=%b want=0", stall);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd5, 3'd2);
    tick();
    idle();
    id_src_valid = 2'b01; id_src_rd = {5'd0, 5'd5};
    issue(5'd6, 3'd0);
    for (int j = 0; j < 4; j++) begin
      settle();
      checks++;
      if (stall !== (j < 2)) begin
        failures++; $display("FAIL load_use_stall cyc=%0d got=%b want=%b", j, stall, (j < 2));
      end
      tick();
    end
    settle();
    checks++;
    if (stall_cnt !== 16'd2) begin
      failures++; $display("FAIL load_use_stall_cnt got=%0d want=2", stall_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_fwd_priority();
    idle();
    stg_rd = {5'd5, 5'd5}; stg_regwrite = 2'b11; ex_src_rd = {5'd0, 5'd5};
    settle();
    checks++;
    if (fwd_sel !== 4'b0001) begin
      failures++; $display("FAIL fwd_prio_young got=%0h want=1", fwd_sel);
    end
    tick();
    stg_regwrite = 2'b10;
    settle();
    checks++;
    if (fwd_sel !== 4'b0010) begin
      failures++; $display("FAIL fwd_prio_old got=%0h want=2", fwd_sel);
    end
    tick();
    stg_rd = {5'd5, 5'd9}; stg_regwrite = 2'b11; ex_src_rd = {5'd9, 5'd5};
    settle();
    checks++;
    if (fwd_sel !== 4'b0110) begin
      failures++; $display("FAIL fwd_two_src got=%0h want=6", fwd_sel);
    end
    tick();
    idle();
  endtask

  task automatic test_reg_zero();
    do_reset();
    issue(5'd0, 3'd4);
    id_src_valid = 2'b11; id_src_rd = '0;
    stg_regwrite = 2'b11; stg_rd = '0; ex_src_rd = '0;
    for (int j = 0; j < 5; j++) begin
      settle();
      checks++;
      if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
        failures++; $display("FAIL reg_zero cyc=%0d stall=%b fwd=%0h want 0/0", j, stall, fwd_sel);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_same_cycle_r7();
    do_reset();
    issue(5'd7, 3'd1);
    tick();
    idle();
    tick();
    tick();
    issue(5'd7, 3'd3);
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    idle();
    id_src_valid = 2'b10; id_src_rd = {5'd7, 5'd0};
    for (int j = 0; j < 5; j++) begin
      settle();
      checks++;
      if (stall !== (j < 3)) begin
        failures++; $display("FAIL issue_retire_r7 cyc=%0d got=%b want=%b", j, stall, (j < 3));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_clamp();
    do_reset();
    issue(5'd9, 3'(MAXLAT + 3));
    tick();
    idle();
    id_src_valid = 2'b01; id_src_rd = {5'd0, 5'd9};
    for (int j = 0; j < 7; j++) begin
      settle();
      checks++;
      if (stall !== (j < MAXLAT)) begin
        failures++; $display("FAIL clamp cyc=%0d got=%b want=%b", j, stall, (j < MAXLAT));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    logic [SW-1:0] f0;
    logic [SW-1:0] f1;
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      id_src_valid = 2'($urandom_range(0, 3));
      id_src_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_valid    = ($urandom_range(0, 3) != 0);
      iss_regwrite = ($urandom_range(0, 4) != 0);
      iss_rd       = 5'($urandom_range(0, 7));
      iss_lat      = 3'($urandom_range(0, 7));
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_rd        = 5'($urandom_range(0, 7));
      ex_src_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_regwrite = 2'($urandom_range(0, 3));
      stg_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      settle();
      f0 = model_fwd(0);
      f1 = model_fwd(1);
      checks++;
      if (stall !== model_stall()) begin
        failures++; $display("FAIL rand_stall n=%0d got=%b want=%b", n, stall, model_stall());
      end
      checks++;
      if (fwd_sel !== {f1, f0}) begin
        failures++; $display("FAIL rand_fwd n=%0d got=%0h want=%0h", n, fwd_sel, {f1, f0});
      end
      checks++;
      if (stall_cnt !== 16'(mcnt)) begin
        failures++; $display("FAIL rand_stall_cnt n=%0d got=%0d want=%0d", n, stall_cnt, mcnt);
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    id_src_valid = 2'b01; id_src_rd = {5'd0, 5'd3};
    issue(5'd3, 3'd4);
    n = 0;
    while (mcnt < 65535 && n < 90000) begin
      tick();
      n++;
    end
    checks++;
    if (mcnt < 65535) begin
      failures++; $display("FAIL sat_budget stalls=%0d want=65535", mcnt);
    end
    for (int j = 0; j < 12; j++) tick();
    settle();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_stall_cnt got=%0h want=ffff", stall_cnt);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    for (int r = 0; r < NREGS; r++) begin
      pend[r]  = 1'b0;
      ready[r] = 0;
    end
    #1;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_reg_zero();
    test_same_cycle_r7();
    test_clamp();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
